// File: rtl/md_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit (ex_muldiv).
//   md_state_e : FSM states (MD_IDLE, MD_RUN)
//   md_hilo_t  : packed {hi, lo} result payload
//   md_cneg    : conditional two's-complement negate of a 32-bit word
package md_pkg;

    localparam int unsigned MD_DATA_W = 32;
    localparam int unsigned MD_PROD_W = 2 * MD_DATA_W;
    localparam int unsigned MD_CNT_W  = 5;
    localparam logic [MD_CNT_W-1:0] MD_LAST = 5'd31;

    // Bit positions inside hilowen / hiloren
    localparam int unsigned MD_HI = 1;
    localparam int unsigned MD_LO = 0;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    typedef struct packed {
        logic [MD_DATA_W-1:0] hi;
        logic [MD_DATA_W-1:0] lo;
    } md_hilo_t;

    function automatic logic [MD_DATA_W-1:0] md_cneg(input logic neg,
                                                     input logic [MD_DATA_W-1:0] x);
        return neg ? (~x + MD_DATA_W'(1)) : x;
    endfunction

endpackage

// File: rtl/md_div_step.sv
// One restoring-division step on a packed {remainder, quotient} word.
//   rq_i      : current {rem[63:32], quo[31:0]}; quo shifts dividend bits out of its MSB
//   divisor_i : divisor magnitude
//   rq_o      : {rem, quo} after shifting in one dividend bit and one quotient bit
// A zero divisor always "fits", so after 32 steps quo is all ones and rem holds the dividend.
module md_div_step
    import md_pkg::*;
(
    input  logic [MD_PROD_W-1:0] rq_i,
    input  logic [MD_DATA_W-1:0] divisor_i,
    output logic [MD_PROD_W-1:0] rq_o
);

    logic [MD_DATA_W:0]   part_rem;
    logic                 fits;
    logic [MD_DATA_W-1:0] diff;
    logic [MD_DATA_W-1:0] rem_next;

    // Partial remainder is 33 bits wide before the compare
    assign part_rem = {rq_i[MD_PROD_W-1:MD_DATA_W], rq_i[MD_DATA_W-1]};
    assign fits     = (part_rem >= {1'b0, divisor_i});
    // When it fits the difference is below the divisor, so 32 bits suffice
    assign diff     = part_rem[MD_DATA_W-1:0] - divisor_i;
    assign rem_next = fits ? diff : part_rem[MD_DATA_W-1:0];
    assign rq_o     = {rem_next, rq_i[MD_DATA_W-2:0], fits};

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit with architectural HI/LO registers.
// Ports:
//   clk, resetn        : clock, synchronous active-low reset
//   en, adv, flush     : instruction valid, EX advance, pipeline refresh
//   mult, div, mdsign  : operation request and signedness
//   hilowen, hiloren   : [1]=HI, [0]=LO write/read selects (MTHI/MTLO, MFHI/MFLO)
//   a, b               : GPR[rs], GPR[rt]
//   hilo_rdata         : combinational HI/LO read data (HI has priority)
//   busy               : combinational stall request
//   hi, lo             : architectural HI/LO registers
// Configuration: define MD_FAST_MUL_EN for a two-cycle '*' multiply;
// otherwise MULT(U) runs the 32-step shift-add path. DIV(U) is always iterative.
module ex_muldiv
    import md_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              en,
    input  logic              adv,
    input  logic              flush,
    input  logic              mult,
    input  logic              div,
    input  logic              mdsign,
    input  logic [1:0]        hilowen,
    input  logic [1:0]        hiloren,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] hilo_rdata,
    output logic              busy,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    md_state_e             state_q,   state_d;
    logic [MD_CNT_W-1:0]   cnt_q,     cnt_d;
    logic                  done_q,    done_d;
    logic                  is_div_q,  is_div_d;
    logic                  neg_q,     neg_d;      // result (product/quotient) sign
    logic                  neg_rem_q, neg_rem_d;  // remainder takes dividend sign
    logic                  zero_q,    zero_d;     // divisor was zero
    logic [MD_DATA_W-1:0]  opnd_q,    opnd_d;     // multiplicand or divisor magnitude
    logic [MD_PROD_W-1:0]  work_q,    work_d;     // {acc, multiplier} or {rem, quo}
    logic [MD_DATA_W-1:0]  hi_q,      hi_d;
    logic [MD_DATA_W-1:0]  lo_q,      lo_d;

    logic                  a_neg, b_neg;
    logic [MD_DATA_W-1:0]  a_mag, b_mag;
    logic                  start;
    logic                  mt_wr;
    logic [MD_DATA_W:0]    mul_sum;
    logic [MD_PROD_W-1:0]  mul_next;
    logic [MD_PROD_W-1:0]  div_next;
    logic [MD_PROD_W-1:0]  step_next;
    logic [MD_PROD_W-1:0]  prod;
    logic                  fast;
    logic                  last;
    md_hilo_t              res;

    // Operand magnitudes and sign capture
    assign a_neg = mdsign & a[MD_DATA_W-1];
    assign b_neg = mdsign & b[MD_DATA_W-1];
    assign a_mag = md_cneg(a_neg, a);
    assign b_mag = md_cneg(b_neg, b);

    assign start = en & (mult | div) & ~done_q & ~flush & (state_q == MD_IDLE);
    assign mt_wr = en & ~mult & ~div & ~flush;
    assign busy  = (mult | div) & en & ~done_q & ~flush & resetn;

    // Shift-add multiply step: add multiplicand when multiplier LSB is set, shift right
    assign mul_sum  = {1'b0, work_q[MD_PROD_W-1:MD_DATA_W]}
                    + {1'b0, (work_q[0] ? opnd_q : MD_DATA_W'(0))};
    assign mul_next = {mul_sum, work_q[MD_DATA_W-1:1]};

    md_div_step u_div_step (
        .rq_i      (work_q),
        .divisor_i (opnd_q),
        .rq_o      (div_next)
    );

    assign step_next = is_div_q ? div_next : mul_next;

`ifdef MD_FAST_MUL_EN
    // Operand magnitudes are the first stage; the product is written at the next edge
    assign fast = ~is_div_q;
    assign prod = fast ? (MD_PROD_W'(opnd_q) * MD_PROD_W'(work_q[MD_DATA_W-1:0]))
                       : step_next;
`else
    assign fast = 1'b0;
    assign prod = step_next;
`endif

    assign last = (state_q == MD_RUN) & (fast | (cnt_q == MD_LAST));

    // Sign fix-up of the final unsigned result
    always_comb begin
        res = '0;
        if (is_div_q) begin
            res.lo = zero_q ? {MD_DATA_W{1'b1}} : md_cneg(neg_q, prod[MD_DATA_W-1:0]);
            res.hi = md_cneg(neg_rem_q, prod[MD_PROD_W-1:MD_DATA_W]);
        end else begin
            res = neg_q ? (~prod + MD_PROD_W'(1)) : prod;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        opnd_d    = opnd_q;
        work_d    = work_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        if (flush) begin
            state_d = MD_IDLE;
            done_d  = 1'b0;
        end else begin
            if (adv) begin
                done_d = 1'b0;
            end
            if (mt_wr && hilowen[MD_HI]) begin
                hi_d = a;
            end
            if (mt_wr && hilowen[MD_LO]) begin
                lo_d = a;
            end
            case (state_q)
                MD_IDLE: begin
                    if (start) begin
                        state_d   = MD_RUN;
                        cnt_d     = '0;
                        is_div_d  = div;
                        neg_d     = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        zero_d    = (b == MD_DATA_W'(0));
                        opnd_d    = div ? b_mag : a_mag;
                        work_d    = {MD_DATA_W'(0), (div ? a_mag : b_mag)};
                    end
                end
                MD_RUN: begin
                    work_d = step_next;
                    cnt_d  = cnt_q + MD_CNT_W'(1);
                    if (last) begin
                        hi_d    = res.hi;
                        lo_d    = res.lo;
                        done_d  = 1'b1;
                        state_d = MD_IDLE;
                    end
                end
                default: state_d = MD_IDLE;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            opnd_q    <= '0;
            work_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
            opnd_q    <= opnd_d;
            work_q    <= work_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;
    assign hilo_rdata = hiloren[MD_HI] ? hi_q :
                        hiloren[MD_LO] ? lo_q : MD_DATA_W'(0);

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: vector table of MULT/DIV operations plus
// hand-written sequences for MTHI/MTLO, done hold, flush, en drop and reset.
module tb_ex_muldiv;

`ifdef MD_FAST_MUL_EN
    localparam int MUL_CYC = 2;
`else
    localparam int MUL_CYC = 33;
`endif
    localparam int DIV_CYC = 33;

    logic        clk = 1'b0;
    logic        resetn, en, adv, flush, mult, div, mdsign;
    logic [1:0]  hilowen, hiloren;
    logic [31:0] a, b;
    logic [31:0] hilo_rdata, hi, lo;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        sgn;
        logic        is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vt [12];

    ex_muldiv #(.DATA_W(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .en         (en),
        .adv        (adv),
        .flush      (flush),
        .mult       (mult),
        .div        (div),
        .mdsign     (mdsign),
        .hilowen    (hilowen),
        .hiloren    (hiloren),
        .a          (a),
        .b          (b),
        .hilo_rdata (hilo_rdata),
        .busy       (busy),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue an op at a negedge and count busy cycles until it drops
    task automatic run_op(input logic is_div, input logic sgn,
                          input logic [31:0] ra, input logic [31:0] rb, output int cyc);
        @(negedge clk);
        en = 1'b1; mult = ~is_div; div = is_div; mdsign = sgn;
        a = ra; b = rb; adv = 1'b0; hiloren = 2'b01;
        #1;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
            #1;
        end
    endtask

    // Instruction leaves EX
    task automatic retire();
        en = 1'b0; mult = 1'b0; div = 1'b0; adv = 1'b1;
        @(negedge clk);
        adv = 1'b0;
    endtask

    initial begin
        int cyc;

        vt[0]  = '{1'b1, 1'b0, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vt[1]  = '{1'b0, 1'b0, 32'd2,         32'd3,        32'h0000_0000, 32'h0000_0006};
        vt[2]  = '{1'b0, 1'b1, 32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E};
        vt[3]  = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vt[4]  = '{1'b1, 1'b1, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF};
        vt[5]  = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vt[6]  = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vt[7]  = '{1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vt[8]  = '{1'b1, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vt[9]  = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1,        32'h0000_0000, 32'hFFFF_FFFF};
        vt[10] = '{1'b1, 1'b1, 32'hFFFF_EDCC, 32'd0,        32'hFFFF_EDCC, 32'hFFFF_FFFF};
        vt[11] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

        resetn = 1'b0; en = 1'b0; adv = 1'b0; flush = 1'b0; mult = 1'b0; div = 1'b0;
        mdsign = 1'b0; hilowen = 2'b00; hiloren = 2'b00; a = '0; b = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset rdata", hilo_rdata, 32'h0);

        // MTHI: write visible only from the next cycle, never busy
        @(negedge clk);
        en = 1'b1; hilowen = 2'b10; a = 32'hDEAD_BEEF; hiloren = 2'b10;
        #1;
        check("mthi busy", 32'(busy), 32'd0);
        check("mthi no bypass", hilo_rdata, 32'h0);
        @(negedge clk);
        en = 1'b0; hilowen = 2'b00;
        #1;
        check("mfhi rdata", hilo_rdata, 32'hDEAD_BEEF);
        check("mthi lo untouched", lo, 32'h0);
        check("mfhi busy", 32'(busy), 32'd0);
        // MTLO and read-select priority
        @(negedge clk);
        en = 1'b1; hilowen = 2'b01; a = 32'h0BAD_F00D;
        @(negedge clk);
        en = 1'b0; hilowen = 2'b00; hiloren = 2'b01;
        #1;
        check("mflo rdata", hilo_rdata, 32'h0BAD_F00D);
        hiloren = 2'b11;
        #1;
        check("rdata hi priority", hilo_rdata, 32'hDEAD_BEEF);
        hiloren = 2'b00;
        #1;
        check("rdata none", hilo_rdata, 32'h0);

        // Vector table
        for (int i = 0; i < 12; i++) begin
            run_op(vt[i].is_div, vt[i].sgn, vt[i].a, vt[i].b, cyc);
            check($sformatf("vec%0d busy cycles", i), 32'(cyc),
                  32'(vt[i].is_div ? DIV_CYC : MUL_CYC));
            check($sformatf("vec%0d hi", i), hi, vt[i].hi);
            check($sformatf("vec%0d lo", i), lo, vt[i].lo);
            check($sformatf("vec%0d rdata", i), hilo_rdata, vt[i].lo);
            retire();
        end

        // Completion with adv held low: no restart, then adv clears done
        run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, cyc);
        check("hold busy cycles", 32'(cyc), 32'(MUL_CYC));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("hold%0d busy", k), 32'(busy), 32'd0);
            check($sformatf("hold%0d lo", k), lo, 32'hFFFF_FFEB);
        end
        adv = 1'b1;
        #1;
        check("adv cycle busy", 32'(busy), 32'd0);
        @(negedge clk);
        adv = 1'b0;
        #1;
        check("done cleared busy", 32'(busy), 32'd1);
        flush = 1'b1;
        #1;
        check("flush busy", 32'(busy), 32'd0);
        @(negedge clk);
        flush = 1'b0; en = 1'b0; mult = 1'b0;
        #1;
        check("post flush busy", 32'(busy), 32'd0);
        check("post flush hi", hi, 32'hFFFF_FFFF);

        // Flush a DIV at cnt=10: HI/LO untouched
        @(negedge clk);
        en = 1'b1; div = 1'b1; mdsign = 1'b0; a = 32'd100; b = 32'd7;
        repeat (11) @(negedge clk);
        #1;
        check("div run busy", 32'(busy), 32'd1);
        flush = 1'b1;
        #1;
        check("div flush busy", 32'(busy), 32'd0);
        @(negedge clk);
        flush = 1'b0; en = 1'b0; div = 1'b0;
        #1;
        check("div flushed busy", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);
        #1;
        check("div flushed hi", hi, 32'hFFFF_FFFF);
        check("div flushed lo", lo, 32'hFFFF_FFEB);

        run_op(1'b0, 1'b0, 32'd2, 32'd3, cyc);
        check("multu after flush cycles", 32'(cyc), 32'(MUL_CYC));
        check("multu after flush hi", hi, 32'h0);
        check("multu after flush lo", lo, 32'h6);
        retire();

        // en dropped after start: the divide still completes
        @(negedge clk);
        en = 1'b1; div = 1'b1; mdsign = 1'b0; a = 32'd1000; b = 32'd10;
        @(negedge clk);
        en = 1'b0;
        #1;
        check("en low busy", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);
        #1;
        check("en low lo", lo, 32'd100);
        check("en low hi", hi, 32'd0);
        retire();

        // Reset in the middle of a divide
        @(negedge clk);
        en = 1'b1; div = 1'b1; mdsign = 1'b1; a = 32'hFFFF_FFF9; b = 32'd2;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("rst mid busy", 32'(busy), 32'd0);
        @(negedge clk);
        resetn = 1'b1; en = 1'b0; div = 1'b0;
        #1;
        check("rst mid hi", hi, 32'h0);
        check("rst mid lo", lo, 32'h0);
        repeat (40) @(negedge clk);
        #1;
        check("rst mid lo later", lo, 32'h0);
        check("rst mid busy later", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
